// File: rtl/set_assoc_cache_pkg.sv
// rtl/set_assoc_cache_pkg.sv - shared constants and line type for the two-way data cache
package set_assoc_cache_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_SET_BITS   = 3;
  localparam int NUM_WAYS       = 2;

  typedef struct packed {
    logic                                     valid;
    logic [DEF_ADDR_WIDTH-DEF_SET_BITS-1:0]   tag;
    logic [DEF_DATA_WIDTH-1:0]                data;
  } cache_line_t;
endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - storage for one cache way: per-set valid/tag/data, tag compare and read
module cache_way
  import set_assoc_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEF_ADDR_WIDTH - DEF_SET_BITS,
  parameter int SET_BITS   = DEF_SET_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [SET_BITS-1:0]   i_idx,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [DATA_WIDTH-1:0] i_wd,
  output logic                  o_match,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int NUM_SETS = 1 << SET_BITS;

  logic [NUM_SETS-1:0]   r_valid;
  logic [TAG_WIDTH-1:0]  r_tag  [NUM_SETS];
  logic [DATA_WIDTH-1:0] r_data [NUM_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; a cleared valid bit hides whatever they hold.
  always_ff @(posedge clk) begin
    if (rst_n && i_we) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_wd;
    end
  end

  assign o_match = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
  assign o_data  = r_data[i_idx];
endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - two-way write-allocate cache; CACHE_LRU_EN selects LRU, else round-robin
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SET_BITS   = DEF_SET_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [ADDR_WIDTH-1:0] A,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] DATA_OUT
);
  localparam int NUM_SETS  = 1 << SET_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_BITS;

  logic [SET_BITS-1:0]   w_idx;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic [NUM_WAYS-1:0]   w_match;
  logic [DATA_WIDTH-1:0] w_data [NUM_WAYS];
  logic [NUM_WAYS-1:0]   w_way_we;
  logic                  w_hit_way;
  logic [NUM_SETS-1:0]   r_repl;

  assign w_idx = A[SET_BITS-1:0];
  assign w_tag = A[ADDR_WIDTH-1:SET_BITS];

  // Way 0 wins if both ever match, so the hitting way is way 1 only when way 0 misses.
  assign hit       = |w_match;
  assign w_hit_way = ~w_match[0];

  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_way
    assign w_way_we[k] = WE && (hit ? (w_hit_way == 1'(k)) : (r_repl[w_idx] == 1'(k)));

    cache_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .SET_BITS   (SET_BITS)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_way_we[k]),
      .i_idx   (w_idx),
      .i_tag   (w_tag),
      .i_wd    (WD),
      .o_match (w_match[k]),
      .o_data  (w_data[k])
    );
  end

  always_comb begin
    DATA_OUT = '0;
    if (w_match[0]) begin
      DATA_OUT = w_data[0];
    end else if (w_match[1]) begin
      DATA_OUT = w_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_repl <= '0;
`ifdef CACHE_LRU_EN
    end else if (hit) begin
      r_repl[w_idx] <= ~w_hit_way;
`endif
    end else if (WE && !hit) begin
      r_repl[w_idx] <= ~r_repl[w_idx];
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - self-checking bench for set_assoc_cache with a behavioural reference model
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] WD = '0;
  logic [31:0] A = '0;
  logic        hit;
  logic [31:0] DATA_OUT;

  int vectors = 0;
  int errors  = 0;

  bit          mv [8][2];
  logic [28:0] mt [8][2];
  logic [31:0] md [8][2];
  int          mr [8];

  set_assoc_cache dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WE       (WE),
    .WD       (WD),
    .A        (A),
    .hit      (hit),
    .DATA_OUT (DATA_OUT)
  );

  always #5 clk = ~clk;

  function automatic int m_find(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (mv[a[2:0]][w] && mt[a[2:0]][w] == a[31:3]) return w;
    return -1;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a);
    int w = m_find(a);
    return (w < 0) ? 32'h0 : md[a[2:0]][w];
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 8; s++) begin
      mv[s][0] = 0; mv[s][1] = 0; mr[s] = 0;
    end
  endtask

  task automatic m_edge(input logic we, input logic [31:0] wd, input logic [31:0] a);
    int s = int'(a[2:0]);
    int w = m_find(a);
    if (w >= 0) begin
      if (we) md[s][w] = wd;
`ifdef CACHE_LRU_EN
      mr[s] = 1 - w;
`endif
    end else if (we) begin
      mv[s][mr[s]] = 1;
      mt[s][mr[s]] = a[31:3];
      md[s][mr[s]] = wd;
      mr[s] = 1 - mr[s];
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s A=%08h got %08h expected %08h", name, A, act, exp);
    end
  endtask

  task automatic check_model();
    cmp("model_hit", {31'b0, hit}, (m_find(A) >= 0) ? 32'd1 : 32'd0);
    cmp("model_data", DATA_OUT, m_data(A));
  endtask

  task automatic cycle(input logic we, input logic [31:0] wd, input logic [31:0] a);
    WE = we; WD = wd; A = a;
    @(negedge clk);
    check_model();
    @(posedge clk);
    m_edge(we, wd, a);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] a, input logic eh, input logic [31:0] ed);
    WE = 1'b0; A = a;
    @(negedge clk);
    check_model();
    cmp({name, "_hit"}, {31'b0, hit}, {31'b0, eh});
    cmp({name, "_data"}, DATA_OUT, ed);
    @(posedge clk);
    m_edge(1'b0, 32'h0, a);
    #1;
  endtask

  initial begin
    m_reset();
    #12;
    cmp("in_reset_hit", {31'b0, hit}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    lit("cold", 32'h0001_0000, 1'b0, 32'h0);
    cycle(1'b1, 32'hDEAD_BEEF, 32'h0001_0000);
    lit("fill0", 32'h0001_0000, 1'b1, 32'hDEAD_BEEF);
    cycle(1'b1, 32'h1234_5678, 32'h0001_0008);
    lit("fill1", 32'h0001_0008, 1'b1, 32'h1234_5678);
    lit("hold0", 32'h0001_0000, 1'b1, 32'hDEAD_BEEF);
    cycle(1'b1, 32'hCAFE_F00D, 32'h0001_0010);
`ifdef CACHE_LRU_EN
    lit("evict_gone", 32'h0001_0008, 1'b0, 32'h0);
    lit("evict_kept", 32'h0001_0000, 1'b1, 32'hDEAD_BEEF);
`else
    lit("evict_gone", 32'h0001_0000, 1'b0, 32'h0);
    lit("evict_kept", 32'h0001_0008, 1'b1, 32'h1234_5678);
`endif
    lit("evict_new", 32'h0001_0010, 1'b1, 32'hCAFE_F00D);

    cycle(1'b1, 32'h1111_1111, 32'h0001_0010);
    lit("update", 32'h0001_0010, 1'b1, 32'h1111_1111);
`ifdef CACHE_LRU_EN
    lit("update_other", 32'h0001_0000, 1'b1, 32'hDEAD_BEEF);
`else
    lit("update_other", 32'h0001_0008, 1'b1, 32'h1234_5678);
`endif

    cycle(1'b1, 32'hAAAA_0001, 32'h0001_0001);
    cycle(1'b1, 32'hBBBB_0002, 32'h0001_0002);
    lit("idx1", 32'h0001_0001, 1'b1, 32'hAAAA_0001);
    lit("idx2", 32'h0001_0002, 1'b1, 32'hBBBB_0002);
    lit("idx_set0", 32'h0001_0010, 1'b1, 32'h1111_1111);

    WE = 1'b1; WD = 32'h5555_5555; A = 32'h0001_0010;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    cmp("async_rst_hit", {31'b0, hit}, 32'd0);
    cmp("async_rst_data", DATA_OUT, 32'h0);
    @(posedge clk); #1;
    A = 32'h0001_0001;
    #1;
    cmp("rst_held_hit", {31'b0, hit}, 32'd0);
    WE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    lit("rst_no_store", 32'h0001_0010, 1'b0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra;
      ra = 32'h0001_0000 | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
      cycle(1'($urandom_range(0, 1)), $urandom, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
endmodule
